// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_pkg: shared types and helpers for the MEM-stage bus controller.
//   size_e  : access size encodings (byte/half/word/dword)
//   state_e : controller FSM states
//   LANES   : byte lanes for the default 32-bit bus; lanes_of() derives it
//             for any DATA_W so parameterised modules stay consistent.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DATA_W_DFLT = 32;
  localparam int LANES       = DATA_W_DFLT / 8;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  // Number of bytes moved by an access of the given size encoding.
  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: external request/acknowledge data bus.
//   cyc   : bus cycle active          we    : write enable
//   sel   : byte-lane enables         addr  : lane-aligned byte address
//   wdata : lane-replicated store     rdata : read data from the slave
//   ack   : one-cycle acknowledge from the slave
// master = controller side, slave = memory side.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  cyc;
  logic                  we;
  logic [DATA_W/8-1:0]   sel;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;

  modport master (output cyc, we, sel, addr, wdata, input rdata, ack);
  modport slave  (input cyc, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bus_ctrl_lane_fmt.sv
// mem_lane_fmt: purely combinational lane formatter.
//   size_i/signed_i/addr_lo_i : access size, load extension mode, low address bits
//   wdata_i  -> wdata_o       : right-justified store data replicated into every slot
//   rdata_i  -> rdata_o       : bus data, selected slot right-justified and extended
//   sel_o                     : byte-lane enables (offset 0 = most significant lane)
//   misalign_o                : access not naturally aligned or size too wide for bus
module mem_lane_fmt
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  input  logic [2:0]          addr_lo_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                misalign_o
);
  localparam int NL   = lanes_of(DATA_W);
  localparam int OFFW = $clog2(NL);

  int                nb;
  int                off;
  int                sh;
  logic [DATA_W-1:0] slot;
  logic [DATA_W-1:0] mask;
  logic              fill;

  always_comb begin
    nb         = size_bytes(size_i);
    misalign_o = (nb > NL) || ((addr_lo_i & 3'(nb - 1)) != 3'b000);
    // Clamp so an illegal dword on a 32-bit bus still yields in-range shifts.
    if (nb > NL) nb = NL;
    off = int'(addr_lo_i[OFFW-1:0]);
    // Big-endian: the slot's lowest lane index counts down from the top.
    sh = NL - off - nb;
    if (sh < 0) sh = 0;
    sel_o = NL'(((1 << nb) - 1) << sh);

    case (size_i)
      SZ_BYTE: wdata_o = {NL{wdata_i[7:0]}};
      SZ_HALF: wdata_o = {(NL/2){wdata_i[15:0]}};
      SZ_WORD: wdata_o = {(NL/4){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase

    slot    = rdata_i >> (8 * sh);
    // Shifting all-ones by the full width gives 0, so full-width loads pass through.
    mask    = ~({DATA_W{1'b1}} << (8 * nb));
    fill    = signed_i & (|(slot & (mask ^ (mask >> 1))));
    rdata_o = (slot & mask) | (fill ? ~mask : '0);
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store controller for a wait-state bus.
//   clk, reset            : clock, asynchronous active-high reset
//   req_i/we_i/size_i/signed_i/addr_i/wdata_i : access request from MEM stage
//   flush_i               : pipeline flush; suppresses completion, never aborts bus
//   rdata_o/done_o/err_o  : one-cycle completion pulse with extended load data
//   stallreq_o            : held while an access is outstanding
//   bus                   : master side of the external bus
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stallreq_o,
  mem_bus_ctrl_if.master    bus
);
  localparam int NL = lanes_of(DATA_W);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                fp_q, fp_d;       // flush seen during the bus cycle
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic [NL-1:0]       sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [NL-1:0]       f_sel;
  logic [DATA_W-1:0]   f_wdata, f_rdata;
  logic                f_mis;

  // Request inputs are held stable while stalled, so the formatter can
  // work on live inputs both at acceptance and when the ack arrives.
  mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size_i    (size_i),
    .signed_i  (signed_i),
    .addr_lo_i (addr_i[2:0]),
    .wdata_i   (wdata_i),
    .rdata_i   (bus.rdata),
    .sel_o     (f_sel),
    .wdata_o   (f_wdata),
    .rdata_o   (f_rdata),
    .misalign_o(f_mis)
  );

  assign bus.cyc   = (state_q == ACCESS);
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fp_d       = fp_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    stallreq_o = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    rdata_o    = '0;
    case (state_q)
      IDLE: begin
        stallreq_o = req_i & ~flush_i;
        if (req_i && !flush_i) begin
          err_d   = f_mis;
          rdata_d = '0;
          cnt_d   = '0;
          if (f_mis) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
            we_d    = we_i;
            sel_d   = f_sel;
            addr_d  = addr_i & ~ADDR_W'(NL - 1);
            wdata_d = f_wdata;
          end
        end
      end
      ACCESS: begin
        stallreq_o = 1'b1;
        cnt_d      = cnt_q + 8'd1;
        if (flush_i) fp_d = 1'b1;
        // Ack is tested first so it wins over a same-cycle timeout.
        if (bus.ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : f_rdata;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
        if (state_d == DONE) begin
          we_d    = 1'b0;
          sel_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        fp_d    = 1'b0;
        cnt_d   = '0;
        if (!fp_q && !flush_i) begin
          done_o  = 1'b1;
          err_o   = err_q;
          rdata_o = rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fp_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
